// File: rtl/seq_pattern_tx.sv
// Serial pattern burst generator: sends the low len bits of a latched pattern
// MSB-first, repeated reps+1 times with gap idle cycles between frames.
module seq_pattern_tx #(
  parameter int W = 8,
  localparam int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [3:0]    reps,
  input  logic [3:0]    gap,
  input  logic          abort,
  output logic          x,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [3:0]    left_q, left_d;
  logic [3:0]    gap_q, gap_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic          reject;
  logic          len_ok;
  logic          x_d, valid_d, busy_d, done_d, err_d;

  assign len_ok = (len != '0) && (len <= LW'(W));

  // State, burst configuration and outputs all update together; outputs are
  // computed from the next-state values so they are true registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      x       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      x       <= x_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default for every comb output prevents latch inference.
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    left_d  = left_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here
        if (start) begin
          if (len_ok) begin
            state_d = SEND;
            pat_d   = pattern;
            len_d   = len;
            left_d  = reps;
            gap_d   = gap;
            idx_d   = len - LW'(1);
          end else begin
            reject = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - LW'(1);
        end else if (left_q != '0) begin
          left_d = left_q - 4'd1;
          idx_d  = len_q - LW'(1);
          if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_q - 4'd1;
          end
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gcnt_q == '0) begin
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs as a pure function of the upcoming state and registers.
  always_comb begin
    valid_d = (state_d == SEND);
    x_d     = valid_d && (|(pat_d & (W'(1) << idx_d)));
    busy_d  = (state_d == SEND) || (state_d == GAP);
    done_d  = (state_d == DONE);
    err_d   = reject;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter W, default 8: maximum pattern length in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1: synchronous active-low reset, sampled only on posedge clk.
REQ-004 SHALL have port start, input, 1: request to transmit one burst.
REQ-005 SHALL have port pattern, input, W: bits to send; the low len bits are used.
REQ-006 SHALL have port len, input, clog2(W+1): number of pattern bits per frame.
REQ-007 SHALL have port reps, input, 4: extra frames in the burst; total frames = reps+1.
REQ-008 SHALL have port gap, input, 4: idle cycles inserted between frames.
REQ-009 SHALL have port abort, input, 1: cancel the current burst.
REQ-010 SHALL have port x, output, 1: serial bit stream; drives a sequence detector's x input.
REQ-011 SHALL have port valid, output, 1: x carries a pattern bit this cycle.
REQ-012 SHALL have port busy, output, 1: a burst is in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a burst completes normally.
REQ-014 SHALL have port err, output, 1: one-cycle pulse when a start request is rejected.

Function
REQ-015 SHALL be a Moore FSM with states IDLE, SEND, GAP and DONE; all outputs SHALL be registered and SHALL depend only on state and internal registers.
REQ-016 In IDLE with start=1 and 1<=len<=W, SHALL latch pattern, len, reps and gap, then enter SEND.
REQ-017 In IDLE with start=1 and len=0 or len>W, SHALL stay in IDLE and pulse err for exactly the next cycle.
REQ-018 A start sampled at edge N SHALL make the first bit appear on x with valid=1 in the cycle after edge N (latency 1).
REQ-019 SEND SHALL output latched pattern bits MSB-first over the used field (pattern[len-1] down to pattern[0]), one bit per cycle, with valid=1.
REQ-020 After bit 0 of a frame, SHALL behave as follows:
- frames remaining, gap>0: enter GAP.
- frames remaining, gap=0: start the next frame in SEND with no bubble.
- no frames remaining: enter DONE.
REQ-021 GAP SHALL last exactly gap cycles with x=0 and valid=0, then return to SEND.
REQ-022 DONE SHALL last one cycle with done=1, x=0, valid=0 and busy=0, then return to IDLE.
REQ-023 busy SHALL be 1 in SEND and GAP, and 0 in IDLE and DONE.
REQ-024 When valid=0, x SHALL be 0.
REQ-025 While busy=1, start SHALL be ignored, and pattern/len/reps/gap changes SHALL NOT affect the burst in progress.
REQ-026 A start sampled in DONE SHALL be ignored.
REQ-027 abort=1 in SEND or GAP SHALL enter IDLE at the next edge with x=0, valid=0 and busy=0, and SHALL NOT pulse done.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 If abort and start are both 1 in IDLE, abort SHALL be ignored and start SHALL be processed per REQ-016/017.
REQ-030 Bit-index and frame counters SHALL NOT wrap: reps=15 SHALL yield exactly 16 frames, and len=W SHALL send all W bits.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE and set x=0, valid=0, busy=0, done=0 and err=0, and SHALL clear all counters.
REQ-032 Reset SHALL take priority over start and abort.
REQ-033 A reset asserted mid-burst SHALL abort the burst with no done pulse.
REQ-034 The first start SHALL be accepted at the first edge with rst=1.

Verification
REQ-035 pattern=8'b0000_0110, len=4, reps=0, gap=0, start pulse -> x=0,1,1,0 with valid=1 for 4 cycles; done=1 in cycle 5; busy=0 in cycle 5.
REQ-036 pattern=0110, len=4, reps=2, gap=2 -> 0110,00,0110,00,0110 (valid=0 during the gaps); exactly 12 valid bits; one done pulse.
REQ-037 Same as REQ-036 with gap=0 -> 12 consecutive valid bits "011001100110"; a downstream 0110 detector fires 3 times.
REQ-038 len=0, start pulse -> err=1 for 1 cycle; busy, valid and done remain 0.
REQ-039 abort asserted on the 2nd bit of a 4-bit frame -> next cycle IDLE, valid=0, no done; a new start is accepted immediately after.
REQ-040 rst=0 during GAP -> all outputs 0 next cycle; with rst=1 and start=1 on the following edge, the full burst restarts from its first bit.
